dsp_mac_seq: RTL and testbench
==============================

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning the operand width (matches the A and B ports of the DSP48A1 slice).
REQ-002 SHALL have parameter LEN_W, default 8, meaning the width of the beat-count field.
REQ-003 SHALL have parameter PIPE_LAT, default 3, meaning cycles from operand issue to P updated; legal values are 2 or greater.
REQ-004 SHALL use one clock and reset, reset asynchronous and active-high: CLK  in  1  rising-edge clock; RST  in  1  asynchronous active-high reset.
REQ-005 SHALL have port: start  in  1  request a new dot product, sampled only in IDLE.
REQ-006 SHALL have port: len  in  LEN_W  number of operand pairs, sampled with start.
REQ-007 SHALL have ports: s_valid  in  1, s_ready  out  1, s_a  in  DATA_W, s_b  in  DATA_W; these form the operand stream.
REQ-008 SHALL have ports: dsp_a  out  DATA_W and dsp_b  out  DATA_W, driving the slice A and B inputs.
REQ-009 SHALL have ports: dsp_ceab  out  1 (drives CEA and CEB), dsp_cem  out  1, dsp_cep  out  1, dsp_ceopmode  out  1.
REQ-010 SHALL have ports: dsp_opmode  out  8 and dsp_carryin  out  1.
REQ-011 SHALL have port: dsp_p  in  48, the slice P output.
REQ-012 SHALL have ports: res_valid  out  1, res_ready  in  1, result  out  48, busy  out  1.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-014 IDLE: when start=1 and len>0, SHALL latch len into the remaining counter and go to RUN.
REQ-015 IDLE: when start=1 and len=0, SHALL set result=0 and go to DONE, with no beat issued.
REQ-016 SHALL ignore start in every state except IDLE.
REQ-017 SHALL assert s_ready only in RUN.
REQ-018 A beat is s_valid&s_ready. On a beat cycle the block SHALL drive dsp_a=s_a, dsp_b=s_b and dsp_ceab=1.
REQ-019 On non-beat cycles the block SHALL drive dsp_ceab=0.
REQ-020 SHALL hold dsp_cem=1 whenever busy=1.
REQ-021 SHALL mark the first beat of a job "first" and every later beat "accumulate", and decrement remaining on each beat.
REQ-022 On the beat that takes remaining to 0, the block SHALL go to DRAIN.
REQ-023 SHALL carry each beat's valid and first tag through an internal shift pipeline.
REQ-024 PIPE_LAT-2 cycles after a beat, the block SHALL drive dsp_ceopmode=1 and dsp_opmode=8'h01 for a first beat (X=M, Z=0) or 8'h09 for an accumulate beat (X=M, Z=P); at all other times dsp_ceopmode=0 and dsp_opmode holds its last value.
REQ-025 PIPE_LAT-1 cycles after a beat, the block SHALL assert dsp_cep=1 for exactly one cycle; gaps in s_valid therefore SHALL NOT disturb P.
REQ-026 SHALL hold dsp_carryin=0 and opmode bits [7:4]=0 (add, no pre-adder, no carry).
REQ-027 DRAIN: when the pipeline holds no pending beat, SHALL capture result<=dsp_p and go to DONE, so that res_valid rises exactly PIPE_LAT+1 cycles after the last beat.
REQ-028 DONE: SHALL hold res_valid=1 and result stable until res_ready=1, then go to IDLE.
REQ-029 A start presented in the same cycle as the DONE->IDLE exit SHALL be ignored; it is accepted from the next cycle.
REQ-030 SHALL set busy=1 in RUN, DRAIN and DONE, and busy=0 in IDLE.
REQ-031 The remaining counter SHALL never wrap; len=2^LEN_W-1 is legal.
REQ-032 A job SHALL compute result = sum of signed s_a*s_b over len beats, modulo 2^48.

Reset
REQ-033 RST=1 SHALL force IDLE immediately and asynchronously, clear the counter and pipeline, and drive s_ready=0, dsp_ceab=0, dsp_cem=0, dsp_cep=0, dsp_ceopmode=0, dsp_opmode=0, dsp_carryin=0, dsp_a=0, dsp_b=0, res_valid=0, result=0 and busy=0.
REQ-034 Reset mid-job SHALL discard the job; no dsp_cep pulse SHALL follow reset release until a new beat is issued.

Verification
REQ-035 The bench SHALL run: len=3, pairs (2,3),(4,5),(-1,7) back-to-back -> result=19, with res_valid rising 4 cycles after the 3rd beat.
REQ-036 The bench SHALL run: len=2 with a 5-cycle s_valid gap between (10,10) and (1,1) -> result=101, and exactly 2 dsp_cep pulses.
REQ-037 The bench SHALL run: len=0 -> DONE next cycle, result=0, and no dsp_ceab or dsp_cep pulse.
REQ-038 The bench SHALL run: a second job after the first with res_ready held low 3 cycles -> result held stable, and the second job's first opmode=8'h01 (no carry-over of the old P).
REQ-039 The bench SHALL run: RST asserted in RUN after 2 of 4 beats -> all outputs 0 in the same cycle, then a fresh len=1 (3,3) job -> result=9.
REQ-040 The bench SHALL run: start pulsed during RUN and DONE -> ignored, and the beat count is unchanged.

Source files
------------

// File: rtl/dsp_mac_seq.sv
// Sequencer that feeds a DSP48A1 slice to compute a signed dot product over a
// stream of operand pairs, steering the slice clock enables and OPMODE per beat.
module dsp_mac_seq #(
    parameter int DATA_W   = 18,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    output logic [DATA_W-1:0] dsp_a,
    output logic [DATA_W-1:0] dsp_b,
    output logic              dsp_ceab,
    output logic              dsp_cem,
    output logic              dsp_cep,
    output logic              dsp_ceopmode,
    output logic [7:0]        dsp_opmode,
    output logic              dsp_carryin,
    input  logic [47:0]       dsp_p,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [47:0]       result,
    output logic              busy
);

    localparam int DEPTH = PIPE_LAT - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [LEN_W-1:0]   remaining_reg, remaining_next;
    logic               first_reg, first_next;
    logic [47:0]        result_reg, result_next;
    logic [7:0]         opmode_reg;
    logic [DEPTH-1:0]   vld_pipe_reg, first_pipe_reg;
    logic [DEPTH:0]     vld_tap, first_tap;
    logic               beat;
    logic               pending;

    assign s_ready = (state_reg == RUN);
    assign beat    = s_valid & s_ready;

    // Tap d holds the beat issued d cycles ago; tap 0 is the live beat.
    assign vld_tap   = {vld_pipe_reg, beat};
    assign first_tap = {first_pipe_reg, first_reg};
    assign pending   = |vld_pipe_reg;

    assign dsp_a        = beat ? s_a : '0;
    assign dsp_b        = beat ? s_b : '0;
    assign dsp_ceab     = beat;
    assign busy         = (state_reg != IDLE);
    assign dsp_cem      = busy;
    assign dsp_ceopmode = vld_tap[PIPE_LAT-2];
    assign dsp_cep      = vld_tap[PIPE_LAT-1];
    assign dsp_carryin  = 1'b0;
    // A first beat selects Z=0 so a previous job's P never leaks into the sum.
    assign dsp_opmode   = dsp_ceopmode ? (first_tap[PIPE_LAT-2] ? 8'h01 : 8'h09)
                                       : opmode_reg;
    assign res_valid    = (state_reg == DONE);
    assign result       = result_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= IDLE;
            remaining_reg  <= '0;
            first_reg      <= 1'b0;
            result_reg     <= '0;
            opmode_reg     <= '0;
            vld_pipe_reg   <= '0;
            first_pipe_reg <= '0;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            first_reg      <= first_next;
            result_reg     <= result_next;
            opmode_reg     <= dsp_opmode;
            vld_pipe_reg   <= vld_tap[DEPTH-1:0];
            first_pipe_reg <= first_tap[DEPTH-1:0];
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        first_next     = first_reg;
        result_next    = result_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        remaining_next = len;
                        first_next     = 1'b1;
                        state_next     = RUN;
                    end else begin
                        result_next = '0;
                        state_next  = DONE;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    remaining_next = remaining_reg - 1'b1;
                    first_next     = 1'b0;
                    if (remaining_reg == LEN_W'(1))
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!pending) begin
                    result_next = dsp_p;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural DSP48A1 slice model
// (A/B, M, OPMODE and P registers) closing the loop on dsp_p.
module tb_dsp_mac_seq;

    localparam int DW = 18;
    localparam int LW = 8;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic                 start = 1'b0;
    logic [LW-1:0]        len = '0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [DW-1:0]        s_a = '0;
    logic [DW-1:0]        s_b = '0;
    logic [DW-1:0]        dsp_a, dsp_b;
    logic                 dsp_ceab, dsp_cem, dsp_cep, dsp_ceopmode, dsp_carryin;
    logic [7:0]           dsp_opmode;
    logic [47:0]          dsp_p;
    logic                 res_valid;
    logic                 res_ready = 1'b1;
    logic [47:0]          result;
    logic                 busy;

    dsp_mac_seq #(.DATA_W(DW), .LEN_W(LW), .PIPE_LAT(3)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_ceab(dsp_ceab), .dsp_cem(dsp_cem),
        .dsp_cep(dsp_cep), .dsp_ceopmode(dsp_ceopmode), .dsp_opmode(dsp_opmode),
        .dsp_carryin(dsp_carryin), .dsp_p(dsp_p),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Slice model: registered A/B, M, OPMODE and P, each behind its clock enable.
    logic signed [DW-1:0] a_r, b_r;
    logic signed [35:0]   prod;
    logic [47:0]          m_r, p_r;
    logic [7:0]           op_r;
    assign prod  = a_r * b_r;
    assign dsp_p = p_r;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_r <= '0; b_r <= '0; m_r <= '0; p_r <= '0; op_r <= '0;
        end else begin
            if (dsp_ceab) begin a_r <= dsp_a; b_r <= dsp_b; end
            if (dsp_cem) m_r <= {{12{prod[35]}}, prod};
            if (dsp_ceopmode) op_r <= dsp_opmode;
            if (dsp_cep)
                p_r <= ((op_r[3:2] == 2'b10) ? p_r : 48'd0) +
                       ((op_r[1:0] == 2'b01) ? m_r : 48'd0);
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int cep_cnt = 0;
    int ceab_cnt = 0;
    int op_cnt = 0;
    logic [7:0] op_hist [0:1023];
    always @(negedge CLK) begin
        if (dsp_cep) cep_cnt <= cep_cnt + 1;
        if (dsp_ceab) ceab_cnt <= ceab_cnt + 1;
        if (dsp_ceopmode) begin
            op_hist[op_cnt] <= dsp_opmode;
            op_cnt <= op_cnt + 1;
        end
    end

    int total = 0;
    int bad = 0;
    int beat_cyc = 0;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic start_job(input int l);
        start = 1'b1;
        len = LW'(l);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic push(input int a, input int b);
        int g;
        g = 0;
        s_valid = 1'b1;
        s_a = DW'(a);
        s_b = DW'(b);
        while (!s_ready && g < 20) begin @(negedge CLK); g++; end
        if (!s_ready) chk("push_ready", 48'(s_ready), 48'd1);
        beat_cyc = cyc;
        @(negedge CLK);
        s_valid = 1'b0;
    endtask

    task automatic wait_res(output int rise);
        int g;
        g = 0;
        while (!res_valid && g < 1000) begin @(negedge CLK); g++; end
        if (!res_valid) chk("res_timeout", 48'(res_valid), 48'd1);
        rise = cyc;
    endtask

    initial begin
        int rise, cep_s, ceab_s, op_s;
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_s_ready", 48'(s_ready), 48'd0);
        chk("rst_res_valid", 48'(res_valid), 48'd0);
        chk("rst_cem", 48'(dsp_cem), 48'd0);
        RST = 1'b0;
        @(negedge CLK);

        // len=3 back-to-back, result held while res_ready low for 3 cycles
        res_ready = 1'b0;
        op_s = op_cnt;
        start_job(3);
        chk("run_busy", 48'(busy), 48'd1);
        push(2, 3); push(4, 5); push(-1, 7);
        wait_res(rise);
        chk("j1_latency", 48'(rise - beat_cyc), 48'd4);
        chk("j1_result", result, 48'd19);
        chk("j1_op_first", 48'(op_hist[op_s]), 48'h01);
        chk("j1_op_accum", 48'(op_hist[op_s+1]), 48'h09);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("j1_hold_valid", 48'(res_valid), 48'd1);
            chk("j1_hold_result", result, 48'd19);
        end
        res_ready = 1'b1;
        @(negedge CLK);
        chk("j1_idle", 48'(busy), 48'd0);

        // second job must start fresh despite P=19 left in the slice
        op_s = op_cnt;
        start_job(2);
        push(1, 1); push(2, 2);
        wait_res(rise);
        chk("j2_result", result, 48'd5);
        chk("j2_op_first", 48'(op_hist[op_s]), 48'h01);
        @(negedge CLK);

        // 5-cycle gap between beats
        cep_s = cep_cnt; ceab_s = ceab_cnt;
        start_job(2);
        push(10, 10);
        repeat (5) @(negedge CLK);
        push(1, 1);
        wait_res(rise);
        chk("gap_result", result, 48'd101);
        chk("gap_cep_pulses", 48'(cep_cnt - cep_s), 48'd2);
        chk("gap_ceab_pulses", 48'(ceab_cnt - ceab_s), 48'd2);
        @(negedge CLK);

        // len=0 completes next cycle with no slice activity
        cep_s = cep_cnt; ceab_s = ceab_cnt; op_s = op_cnt;
        start_job(0);
        chk("len0_done", 48'(res_valid), 48'd1);
        chk("len0_result", result, 48'd0);
        repeat (4) @(negedge CLK);
        chk("len0_cep", 48'(cep_cnt - cep_s), 48'd0);
        chk("len0_ceab", 48'(ceab_cnt - ceab_s), 48'd0);
        chk("len0_opmode", 48'(op_cnt - op_s), 48'd0);

        // negative product wraps modulo 2^48
        start_job(1);
        push(-3, 5);
        wait_res(rise);
        chk("neg_result", result, 48'hFFFF_FFFF_FFF1);
        @(negedge CLK);

        // start pulses during RUN and at the DONE exit are ignored
        ceab_s = ceab_cnt;
        start_job(3);
        push(1, 2);
        start = 1'b1; len = LW'(7);
        push(3, 4);
        start = 1'b0;
        push(5, 6);
        chk("ign_ready_drop", 48'(s_ready), 48'd0);
        wait_res(rise);
        chk("ign_result", result, 48'd44);
        chk("ign_beats", 48'(ceab_cnt - ceab_s), 48'd3);
        start = 1'b1; len = LW'(1);
        @(negedge CLK);
        start = 1'b0;
        chk("ign_exit_busy", 48'(busy), 48'd0);
        @(negedge CLK);
        chk("ign_exit_busy2", 48'(busy), 48'd0);

        // reset mid-job after 2 of 4 beats
        start_job(4);
        push(7, 7); push(8, 8);
        s_valid = 1'b1; s_a = DW'(5); s_b = DW'(6);
        RST = 1'b1;
        #1;
        chk("mrst_busy", 48'(busy), 48'd0);
        chk("mrst_s_ready", 48'(s_ready), 48'd0);
        chk("mrst_ceab", 48'(dsp_ceab), 48'd0);
        chk("mrst_cem", 48'(dsp_cem), 48'd0);
        chk("mrst_cep", 48'(dsp_cep), 48'd0);
        chk("mrst_ceopmode", 48'(dsp_ceopmode), 48'd0);
        chk("mrst_opmode", 48'(dsp_opmode), 48'd0);
        chk("mrst_carryin", 48'(dsp_carryin), 48'd0);
        chk("mrst_dsp_a", 48'(dsp_a), 48'd0);
        chk("mrst_dsp_b", 48'(dsp_b), 48'd0);
        chk("mrst_res_valid", 48'(res_valid), 48'd0);
        chk("mrst_result", result, 48'd0);
        @(negedge CLK);
        RST = 1'b0; s_valid = 1'b0;
        cep_s = cep_cnt;
        repeat (4) @(negedge CLK);
        chk("mrst_no_cep", 48'(cep_cnt - cep_s), 48'd0);
        start_job(1);
        push(3, 3);
        wait_res(rise);
        chk("mrst_fresh_result", result, 48'd9);
        @(negedge CLK);

        // maximum length job
        ceab_s = ceab_cnt;
        start_job(255);
        for (int i = 0; i < 255; i++) push(1, 1);
        wait_res(rise);
        chk("max_result", result, 48'd255);
        chk("max_beats", 48'(ceab_cnt - ceab_s), 48'd255);
        @(negedge CLK);
        chk("max_idle", 48'(busy), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
